// File: rtl/latch_load_sequencer_pkg.sv
// Shared types and constants for the latch load sequencer: state encoding,
// timer width and default window lengths.
package latch_seq_pkg;

  localparam int unsigned TIMER_W       = 8;
  localparam int unsigned TIMER_MAX     = (1 << TIMER_W) - 1;

  localparam int unsigned DEF_WIDTH     = 8;
  localparam int unsigned DEF_SETUP_CYC = 2;
  localparam int unsigned DEF_EN_CYC    = 3;
  localparam int unsigned DEF_HOLD_CYC  = 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ENABLE = 2'd2,
    HOLD   = 2'd3
  } seq_state_t;

  typedef logic [TIMER_W-1:0] timer_t;

  // A window of N cycles expires when the timer, loaded with N-1, reaches 0.
  function automatic timer_t cyc_to_load(input int unsigned cyc);
    return timer_t'(cyc - 1);
  endfunction

endpackage

// File: rtl/latch_load_sequencer_if.sv
// Upstream valid/ready word handshake into the latch load sequencer.
interface latch_load_sequencer_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/latch_load_sequencer_timer.sv
// 8-bit down-counter that stops at zero; reloaded by the sequencer on every
// state transition.
module latch_seq_timer
  import latch_seq_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   load,
  input  timer_t load_val,
  output logic   zero
);

  timer_t count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - timer_t'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/latch_load_sequencer.sv
// Drives a bank of level-sensitive latches with a registered, glitch-free
// d/en sequence: setup window, enable window, hold window per accepted word.
module latch_load_sequencer
  import latch_seq_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned SETUP_CYC = DEF_SETUP_CYC,
  parameter int unsigned EN_CYC    = DEF_EN_CYC,
  parameter int unsigned HOLD_CYC  = DEF_HOLD_CYC
) (
  input  logic                   clk,
  input  logic                   rst_n,
  latch_load_sequencer_if.slave  up,
  input  logic                   flush,
  output logic [WIDTH-1:0]       d,
  output logic                   en,
  output logic                   busy,
  output logic                   done
);

  if (SETUP_CYC < 1 || SETUP_CYC > TIMER_MAX ||
      EN_CYC    < 1 || EN_CYC    > TIMER_MAX ||
      HOLD_CYC  < 1 || HOLD_CYC  > TIMER_MAX) begin : g_bad_param
    $error("latch_load_sequencer: SETUP_CYC, EN_CYC and HOLD_CYC must be in 1..255");
  end

  localparam timer_t SETUP_LOAD = cyc_to_load(SETUP_CYC);
  localparam timer_t EN_LOAD    = cyc_to_load(EN_CYC);
  localparam timer_t HOLD_LOAD  = cyc_to_load(HOLD_CYC);

  seq_state_t       state_q, state_n;
  logic [WIDTH-1:0] d_q, d_n;
  logic             en_q, en_n;
  logic             ready_q, ready_n;
  logic             busy_q, busy_n;
  logic             done_q, done_n;
  logic             tmr_load;
  timer_t           tmr_val;
  logic             tmr_zero;

  latch_seq_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      d_q     <= '0;
      en_q    <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      d_q     <= d_n;
      en_q    <= en_n;
      ready_q <= ready_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
    end
  end

  // Every output is computed one cycle ahead here and registered above, so
  // en and friends never see a combinational path from the inputs.
  always_comb begin
    state_n  = state_q;
    d_n      = d_q;
    en_n     = en_q;
    ready_n  = ready_q;
    busy_n   = busy_q;
    done_n   = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = '0;

    if (flush && busy_q) begin
      state_n = IDLE;
      en_n    = 1'b0;
      ready_n = 1'b1;
      busy_n  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (up.in_valid && ready_q) begin
            d_n      = up.in_data;
            state_n  = SETUP;
            ready_n  = 1'b0;
            busy_n   = 1'b1;
            tmr_load = 1'b1;
            tmr_val  = SETUP_LOAD;
          end
        end
        SETUP: begin
          if (tmr_zero) begin
            state_n  = ENABLE;
            en_n     = 1'b1;
            tmr_load = 1'b1;
            tmr_val  = EN_LOAD;
          end
        end
        ENABLE: begin
          if (tmr_zero) begin
            state_n  = HOLD;
            en_n     = 1'b0;
            tmr_load = 1'b1;
            tmr_val  = HOLD_LOAD;
          end
        end
        HOLD: begin
          if (tmr_zero) begin
            state_n = IDLE;
            done_n  = 1'b1;
            ready_n = 1'b1;
            busy_n  = 1'b0;
          end
        end
      endcase
    end
  end

  assign up.in_ready = ready_q;
  assign d           = d_q;
  assign en          = en_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule
